// File: rtl/dmem_arb_pkg.sv
// Shared definitions for dmem_arbiter: FSM states, memory operation codes and
// legality helpers (addr_aligned is used only when DMEM_ARB_ALIGN_CHECK_EN is defined).
package dmem_arb_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} arb_state_t;

  localparam logic [2:0] LD_OFF = 3'b000, LD_LW = 3'b001, LD_LH = 3'b010,
                         LD_LHU = 3'b011, LD_LB = 3'b100, LD_LBU = 3'b101;
  localparam logic [1:0] WR_NONE = 2'b00, WR_SW = 2'b01, WR_SH = 2'b10, WR_SB = 2'b11;

  // A transaction may load or store but not both; 110/111 load codes are undefined.
  function automatic logic op_legal(input logic [2:0] rd, input logic [1:0] wr);
    return (rd <= LD_LBU) && ((rd == LD_OFF) || (wr == WR_NONE));
  endfunction

  function automatic logic addr_aligned(input logic [2:0] rd, input logic [1:0] wr,
                                        input logic [1:0] lo);
    logic ok;
    ok = 1'b1;
    if (((rd == LD_LW) || (wr == WR_SW)) && (lo != 2'b00)) ok = 1'b0;
    if (((rd == LD_LH) || (rd == LD_LHU) || (wr == WR_SH)) && lo[0]) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the data-memory port of dmem_arbiter.
// slave = arbiter side, master = requesters plus memory.
interface dmem_arbiter_if;
  logic        p0_req,    p1_req;
  logic [2:0]  p0_rd,     p1_rd;
  logic [1:0]  p0_wr,     p1_wr;
  logic [31:0] p0_addr,   p1_addr;
  logic [31:0] p0_wdata,  p1_wdata;
  logic        p0_gnt,    p1_gnt;
  logic        p0_rvalid, p1_rvalid;
  logic [31:0] p0_rdata,  p1_rdata;
  logic        p0_err,    p1_err;
  logic [2:0]  mem_read;
  logic [1:0]  mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  p0_req, p1_req, p0_rd, p1_rd, p0_wr, p1_wr,
           p0_addr, p1_addr, p0_wdata, p1_wdata, mem_rdata,
    output p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata,
           p0_err, p1_err, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output p0_req, p1_req, p0_rd, p1_rd, p0_wr, p1_wr,
           p0_addr, p1_addr, p0_wdata, p1_wdata, mem_rdata,
    input  p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata,
           p0_err, p1_err, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arb_rr.sv
// Two-way round-robin picker: a lone requester wins, a conflict goes to the
// port that was not granted last.
module dmem_arb_rr (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       winner
);
  assign winner = (&req) ? ~last_grant : req[1];
endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data memory's single load/store port between two masters.
// Optional DMEM_ARB_ALIGN_CHECK_EN rejects misaligned word/half accesses.
module dmem_arbiter
  import dmem_arb_pkg::*;
(
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  arb_state_t  state_reg, state_next;
  logic        last_grant_reg, last_grant_next;
  logic        port_reg, winner;
  logic [2:0]  rd_reg;
  logic [1:0]  wr_reg;
  logic [31:0] addr_reg, wdata_reg, rdata_reg;
  logic        legal_reg, legal_next;
  logic        latch_en, capture_en;
  logic [1:0]  req, gnt_c, rvalid_c;
  logic [2:0]  mem_read_c;
  logic [1:0]  mem_write_c;
  logic [2:0]  rd_in    [2];
  logic [1:0]  wr_in    [2];
  logic [31:0] addr_in  [2];
  logic [31:0] wdata_in [2];

  assign req         = {bus.p1_req, bus.p0_req};
  assign rd_in[0]    = bus.p0_rd;
  assign rd_in[1]    = bus.p1_rd;
  assign wr_in[0]    = bus.p0_wr;
  assign wr_in[1]    = bus.p1_wr;
  assign addr_in[0]  = bus.p0_addr;
  assign addr_in[1]  = bus.p1_addr;
  assign wdata_in[0] = bus.p0_wdata;
  assign wdata_in[1] = bus.p1_wdata;

  dmem_arb_rr u_rr (
    .req        (req),
    .last_grant (last_grant_reg),
    .winner     (winner)
  );

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  assign legal_next = op_legal(rd_in[winner], wr_in[winner]) &&
                      addr_aligned(rd_in[winner], wr_in[winner], addr_in[winner][1:0]);
`else
  assign legal_next = op_legal(rd_in[winner], wr_in[winner]);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= S_IDLE;
      last_grant_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    latch_en        = 1'b0;
    capture_en      = 1'b0;
    gnt_c           = 2'b00;
    rvalid_c        = 2'b00;
    mem_read_c      = LD_OFF;
    mem_write_c     = WR_NONE;
    case (state_reg)
      S_IDLE: begin
        if (|req) begin
          latch_en   = 1'b1;
          state_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        gnt_c[port_reg] = 1'b1;
        capture_en      = 1'b1;
        // Illegal requests still occupy a slot but never touch memory.
        if (legal_reg) begin
          mem_read_c  = rd_reg;
          mem_write_c = wr_reg;
        end
        state_next = S_RESP;
      end
      S_RESP: begin
        rvalid_c[port_reg] = 1'b1;
        last_grant_next    = port_reg;
        state_next         = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      port_reg  <= 1'b0;
      rd_reg    <= LD_OFF;
      wr_reg    <= WR_NONE;
      addr_reg  <= '0;
      wdata_reg <= '0;
      legal_reg <= 1'b0;
      rdata_reg <= '0;
    end else begin
      if (latch_en) begin
        port_reg  <= winner;
        rd_reg    <= rd_in[winner];
        wr_reg    <= wr_in[winner];
        addr_reg  <= addr_in[winner];
        wdata_reg <= wdata_in[winner];
        legal_reg <= legal_next;
      end
      if (capture_en) begin
        rdata_reg <= (legal_reg && (rd_reg != LD_OFF)) ? bus.mem_rdata : '0;
      end
    end
  end

  assign bus.p0_gnt    = gnt_c[0];
  assign bus.p1_gnt    = gnt_c[1];
  assign bus.p0_rvalid = rvalid_c[0];
  assign bus.p1_rvalid = rvalid_c[1];
  assign bus.p0_rdata  = rvalid_c[0] ? rdata_reg : '0;
  assign bus.p1_rdata  = rvalid_c[1] ? rdata_reg : '0;
  assign bus.p0_err    = rvalid_c[0] & ~legal_reg;
  assign bus.p1_err    = rvalid_c[1] & ~legal_reg;
  assign bus.mem_read  = mem_read_c;
  assign bus.mem_write = mem_write_c;
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = wdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed cases, random two-port traffic
// against a byte-array reference model, and a mid-transaction reset.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int          port;
    logic [2:0]  rd;
    logic [1:0]  wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    int          port;
    logic [2:0]  mrd;
    logic [1:0]  mwr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t gnt_q [$];
  exp_t rsp_q [$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   gnt_cyc = 0;
  bit   sb_off = 1'b0;
  int   last_grant = 1;
  int   mon_p;
  exp_t mon_e;

  logic [7:0] mem     [256] = '{default: 8'h00};
  logic [7:0] ref_mem [256] = '{default: 8'h00};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] rd, input logic [1:0] wr);
    if (wr == 2'd1 || rd == 3'd1) return 4;
    if (wr == 2'd2 || rd == 3'd2 || rd == 3'd3) return 2;
    if (wr == 2'd3 || rd == 3'd4 || rd == 3'd5) return 1;
    return 0;
  endfunction

  // Data memory seen by the arbiter: little-endian bytes, combinational load path.
  always @(posedge clk) begin
    for (int i = 0; i < size_of(3'd0, bus.mem_write); i++)
      mem[8'(bus.mem_addr + 32'(i))] <= bus.mem_wdata[8*i +: 8];
  end

  always_comb begin
    logic [31:0] w;
    w = {mem[8'(bus.mem_addr + 32'd3)], mem[8'(bus.mem_addr + 32'd2)],
         mem[8'(bus.mem_addr + 32'd1)], mem[8'(bus.mem_addr)]};
    case (bus.mem_read)
      3'd1:    bus.mem_rdata = w;
      3'd2:    bus.mem_rdata = {{16{w[15]}}, w[15:0]};
      3'd3:    bus.mem_rdata = {16'h0000, w[15:0]};
      3'd4:    bus.mem_rdata = {{24{w[7]}}, w[7:0]};
      3'd5:    bus.mem_rdata = {24'h000000, w[7:0]};
      default: bus.mem_rdata = 32'h0;
    endcase
  end

  // Reference model: outcome of one transaction, applied to the model memory.
  function automatic exp_t predict(input txn_t t);
    exp_t           e;
    bit             legal;
    int             n;
    longint unsigned v;
    n     = size_of(t.rd, t.wr);
    legal = (t.rd <= 3'd5) && (t.rd == 3'd0 || t.wr == 2'd0);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    if (n > 1 && (t.addr % n) != 0) legal = 1'b0;
`endif
    e.port  = t.port;
    e.addr  = t.addr;
    e.wdata = t.wdata;
    e.mrd   = legal ? t.rd : 3'd0;
    e.mwr   = legal ? t.wr : 2'd0;
    e.rdata = 32'h0;
    e.err   = !legal;
    if (legal && t.wr != 2'd0) begin
      for (int i = 0; i < n; i++)
        ref_mem[8'(t.addr + 32'(i))] = 8'((t.wdata >> (8*i)) & 32'hFF);
    end else if (legal && t.rd != 3'd0) begin
      v = 0;
      for (int i = 0; i < n; i++)
        v = v + (longint'(ref_mem[8'(t.addr + 32'(i))]) << (8*i));
      if ((t.rd == 3'd2 || t.rd == 3'd4) && v >= (64'd1 << (8*n - 1)))
        v = v + (64'd1 << 32) - (64'd1 << (8*n));
      e.rdata = v[31:0];
    end
    return e;
  endfunction

  function automatic txn_t mk(input int p, input logic [2:0] rd, input logic [1:0] wr,
                              input logic [31:0] addr, input logic [31:0] wdata);
    txn_t t;
    t.port = p; t.rd = rd; t.wr = wr; t.addr = addr; t.wdata = wdata;
    return t;
  endfunction

  function automatic txn_t rand_txn(input int p);
    txn_t t;
    t = mk(p, 3'd0, 2'd0, $urandom, $urandom);
    t.addr[7:0] = 8'($urandom_range(0, 63));
    case ($urandom_range(0, 9))
      0, 1, 2, 3: t.rd = 3'($urandom_range(1, 5));
      4, 5, 6:    t.wr = 2'($urandom_range(1, 3));
      7:          t.rd = 3'd0;
      8:          t.rd = 3'($urandom_range(6, 7));
      default: begin
        t.rd = 3'($urandom_range(1, 5));
        t.wr = 2'($urandom_range(1, 3));
      end
    endcase
    return t;
  endfunction

  task automatic drive_port(input int p, input txn_t t, input logic req);
    if (p == 0) begin
      bus.p0_req = req; bus.p0_rd = t.rd; bus.p0_wr = t.wr;
      bus.p0_addr = t.addr; bus.p0_wdata = t.wdata;
    end else begin
      bus.p1_req = req; bus.p1_rd = t.rd; bus.p1_wr = t.wr;
      bus.p1_addr = t.addr; bus.p1_wdata = t.wdata;
    end
  endtask

  task automatic run_round(input bit use0, input bit use1, input txn_t t0, input txn_t t1);
    int first;
    int lat [2];
    bit pend [2];
    repeat ($urandom_range(1, 3)) @(negedge clk);
    first  = (use0 && use1) ? ((last_grant == 1) ? 0 : 1) : (use0 ? 0 : 1);
    lat[0] = 0;
    lat[1] = 0;
    gnt_q.push_back(predict((first == 0) ? t0 : t1));
    rsp_q.push_back(gnt_q[$]);
    if (use0 && use1) begin
      gnt_q.push_back(predict((first == 0) ? t1 : t0));
      rsp_q.push_back(gnt_q[$]);
      last_grant = 1 - first;
    end else begin
      last_grant = first;
    end
    pend[0] = use0;
    pend[1] = use1;
    drive_port(0, t0, use0);
    drive_port(1, t1, use1);
    for (int k = 1; k <= 12 && (pend[0] || pend[1]); k++) begin
      @(negedge clk);
      // Scramble inputs right after the grant: the latched copy must be used.
      if (pend[0] && bus.p0_gnt) begin
        pend[0] = 1'b0; lat[0] = k; drive_port(0, rand_txn(0), 1'b0);
      end
      if (pend[1] && bus.p1_gnt) begin
        pend[1] = 1'b0; lat[1] = k; drive_port(1, rand_txn(1), 1'b0);
      end
    end
    if (pend[0] || pend[1]) begin
      n_checks++; n_fail++;
      $display("FAIL gnt_timeout: pending p0=%0b p1=%0b, required grant within 12 cycles",
               pend[0], pend[1]);
      bus.p0_req = 1'b0;
      bus.p1_req = 1'b0;
    end
    if (use0 && use1) begin
      check("gnt_latency_first", 32'(lat[first]), 32'd1);
      check("gnt_latency_second", 32'(lat[1 - first]), 32'd4);
    end else begin
      check("gnt_latency", 32'(lat[first]), 32'd1);
    end
    for (int k = 0; k < 10 && rsp_q.size() != 0; k++) @(negedge clk);
    if (rsp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL rvalid_timeout: %0d responses outstanding, required 0", rsp_q.size());
      gnt_q.delete();
      rsp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_strobes"}, 32'({bus.p1_gnt, bus.p0_gnt, bus.p1_rvalid, bus.p0_rvalid,
                                  bus.p1_err, bus.p0_err}), 32'd0);
    check({tag, "_p0_rdata"}, bus.p0_rdata, 32'd0);
    check({tag, "_p1_rdata"}, bus.p1_rdata, 32'd0);
    check({tag, "_mem_op"}, 32'({bus.mem_read, bus.mem_write}), 32'd0);
    check({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst && !sb_off) begin
      if (bus.p0_gnt || bus.p1_gnt) begin
        mon_p = bus.p1_gnt ? 1 : 0;
        check("gnt_exclusive", 32'(bus.p0_gnt & bus.p1_gnt), 32'd0);
        if (gnt_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_gnt: port %0d granted, required no grant", mon_p);
        end else begin
          mon_e = gnt_q.pop_front();
          check("gnt_port", 32'(mon_p), 32'(mon_e.port));
          check("mem_read", 32'(bus.mem_read), 32'(mon_e.mrd));
          check("mem_write", 32'(bus.mem_write), 32'(mon_e.mwr));
          check("mem_addr", bus.mem_addr, mon_e.addr);
          check("mem_wdata", bus.mem_wdata, mon_e.wdata);
          gnt_cyc = cyc;
        end
      end else begin
        check("mem_idle_op", 32'({bus.mem_read, bus.mem_write}), 32'd0);
      end
      if (bus.p0_rvalid || bus.p1_rvalid) begin
        mon_p = bus.p1_rvalid ? 1 : 0;
        if (rsp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_rvalid: port %0d responded, required no response", mon_p);
        end else begin
          mon_e = rsp_q.pop_front();
          check("rvalid_port", 32'(mon_p), 32'(mon_e.port));
          check("rdata", mon_p ? bus.p1_rdata : bus.p0_rdata, mon_e.rdata);
          check("err", 32'(mon_p ? bus.p1_err : bus.p0_err), 32'(mon_e.err));
          check("resp_latency", 32'(cyc - gnt_cyc), 32'd1);
          $display("txn port%0d addr=%08h mem_rd=%0d mem_wr=%0d rdata=%08h err=%0b",
                   mon_p, mon_e.addr, mon_e.mrd, mon_e.mwr,
                   mon_p ? bus.p1_rdata : bus.p0_rdata, mon_p ? bus.p1_err : bus.p0_err);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    txn_t nop0, nop1;
    bit   got;
    nop0 = mk(0, 3'd0, 2'd0, 32'h0, 32'h0);
    nop1 = mk(1, 3'd0, 2'd0, 32'h0, 32'h0);
    drive_port(0, nop0, 1'b0);
    drive_port(1, nop1, 1'b0);
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;

    run_round(1, 0, mk(0, 3'd0, 2'd1, 32'h10, 32'hDEADBEEF), nop1);
    run_round(1, 0, mk(0, 3'd1, 2'd0, 32'h10, 32'h0), nop1);
    run_round(1, 1, mk(0, 3'd1, 2'd0, 32'h10, 32'h0), mk(1, 3'd1, 2'd0, 32'h10, 32'h0));
    run_round(1, 1, mk(0, 3'd1, 2'd0, 32'h10, 32'h0), mk(1, 3'd1, 2'd0, 32'h10, 32'h0));
    run_round(0, 1, nop0, mk(1, 3'd0, 2'd1, 32'h04, 32'h00000080));
    run_round(0, 1, nop0, mk(1, 3'd4, 2'd0, 32'h04, 32'h0));
    run_round(0, 1, nop0, mk(1, 3'd5, 2'd0, 32'h04, 32'h0));
    run_round(1, 0, mk(0, 3'd1, 2'd1, 32'h10, 32'h11111111), nop1);
    run_round(1, 0, mk(0, 3'd1, 2'd0, 32'h10, 32'h0), nop1);
    run_round(1, 0, mk(0, 3'd7, 2'd0, 32'h10, 32'h0), nop1);
    run_round(1, 0, nop0, nop1);
    run_round(1, 0, mk(0, 3'd1, 2'd0, 32'h06, 32'h0), nop1);
    run_round(1, 0, mk(0, 3'd2, 2'd0, 32'h05, 32'h0), nop1);
    run_round(1, 0, mk(0, 3'd0, 2'd2, 32'h03, 32'hA5A5C3C3), nop1);

    for (int r = 0; r < 150; r++) begin
      int sel;
      sel = $urandom_range(1, 3);
      run_round(sel[0], sel[1], rand_txn(0), rand_txn(1));
    end

    run_round(1, 0, mk(0, 3'd0, 2'd1, 32'h20, 32'hCAFEF00D), nop1);
    repeat (2) @(negedge clk);
    sb_off = 1'b1;
    drive_port(0, mk(0, 3'd0, 2'd1, 32'h20, 32'h12345678), 1'b1);
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      @(negedge clk);
      if (bus.p0_gnt) got = 1'b1;
    end
    check("rst_test_gnt", 32'(got), 32'd1);
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    drive_port(0, nop0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    last_grant = 1;
    sb_off = 1'b0;
    check("mem20_kept", {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]},
          {ref_mem[8'h23], ref_mem[8'h22], ref_mem[8'h21], ref_mem[8'h20]});
    run_round(1, 0, mk(0, 3'd1, 2'd0, 32'h20, 32'h0), nop1);
    run_round(1, 1, mk(0, 3'd1, 2'd0, 32'h20, 32'h0), mk(1, 3'd5, 2'd0, 32'h21, 32'h0));

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
